// File: rtl/seq_sched_pkg.sv
// Shared types and constants for the burst scheduler: FSM state encoding,
// default widths and the requester-ID width helper.
package seq_sched_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } sched_state_t;

    localparam int DEF_NUM_REQ = 2;
    localparam int DEF_LEN_W   = 4;
    localparam int DEF_DATA_W  = 8;

    // Requester ID width; a single bit is kept even when only one ID is possible.
    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/seq_burst_scheduler_if.sv
// Request, generator and output-stream signals of the burst scheduler.
// master = scheduler side, slave = requesters/generator/consumer side.
interface seq_burst_scheduler_if #(
    parameter int NUM_REQ = seq_sched_pkg::DEF_NUM_REQ,
    parameter int LEN_W   = seq_sched_pkg::DEF_LEN_W,
    parameter int DATA_W  = seq_sched_pkg::DEF_DATA_W,
    parameter int ID_W    = seq_sched_pkg::id_width(NUM_REQ)
);
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ*LEN_W-1:0] req_len;
    logic [NUM_REQ-1:0]       req_ready;
    logic [DATA_W-1:0]        gen_data;
    logic                     gen_enable;
    logic                     gen_restart;
    logic                     out_valid;
    logic [DATA_W-1:0]        out_data;
    logic [ID_W-1:0]          out_id;
    logic                     out_last;
    logic                     out_ready;
    logic                     busy;

    modport master (
        input  req_valid, req_len, gen_data, out_ready,
        output req_ready, gen_enable, gen_restart,
               out_valid, out_data, out_id, out_last, busy
    );

    modport slave (
        output req_valid, req_len, gen_data, out_ready,
        input  req_ready, gen_enable, gen_restart,
               out_valid, out_data, out_id, out_last, busy
    );
endinterface

// File: rtl/seq_rr_arbiter.sv
// Round-robin arbiter: searches upward from the priority pointer with wrap;
// the pointer moves past the winner only when the grant is actually accepted.
module seq_rr_arbiter
    import seq_sched_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int ID_W    = id_width(NUM_REQ)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic               accept,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_id,
    output logic               grant_any
);

    logic [ID_W-1:0] ptr;

    always_comb begin
        int idx;
        idx       = 0;
        grant     = '0;
        grant_id  = '0;
        grant_any = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (!grant_any && req[idx]) begin
                grant_any  = 1'b1;
                grant[idx] = 1'b1;
                grant_id   = ID_W'(idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
        end else if (accept) begin
            ptr <= (int'(grant_id) == NUM_REQ - 1) ? '0 : grant_id + 1'b1;
        end
    end

endmodule

// File: rtl/seq_burst_scheduler.sv
// Shares one sequence generator between NUM_REQ burst requesters, streaming
// L+1 generator words per grant. Optional macro: SEQ_SCHED_RESTART_EN.
//
//  state  | meaning
//  IDLE   | no burst in flight; grants the round-robin winner when any request is up
//  STREAM | presents generator words for the owning requester until out_last is taken
module seq_burst_scheduler
    import seq_sched_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int LEN_W   = DEF_LEN_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ID_W    = id_width(NUM_REQ)
) (
    input logic                   clk,
    input logic                   reset,
    seq_burst_scheduler_if.master bus
);

    sched_state_t       state;
    logic [LEN_W-1:0]   remaining;
    logic [ID_W-1:0]    owner_id;

    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_id;
    logic               grant_any;
    logic               accept;
    logic               stream;
    logic               handshake;
    logic [LEN_W-1:0]   len_sel;

    assign stream    = (state == STREAM);
    assign accept    = (state == IDLE) & grant_any & ~reset;
    assign handshake = stream & bus.out_ready & ~reset;

    seq_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .clk       (clk),
        .reset     (reset),
        .req       (bus.req_valid),
        .accept    (accept),
        .grant     (grant),
        .grant_id  (grant_id),
        .grant_any (grant_any)
    );

    always_comb begin
        len_sel = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grant[k]) begin
                len_sel = bus.req_len[k*LEN_W +: LEN_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            remaining <= '0;
            owner_id  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        remaining <= len_sel;
                        owner_id  <= grant_id;
                        state     <= STREAM;
                    end
                end
                STREAM: begin
                    // remaining counts words after the current one, so zero marks the last
                    if (bus.out_ready) begin
                        if (remaining == '0) begin
                            state <= IDLE;
                        end else begin
                            remaining <= remaining - 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready  = accept ? grant : '0;
    assign bus.out_valid  = stream;
    assign bus.busy       = stream;
    assign bus.out_data   = bus.gen_data;
    assign bus.out_id     = owner_id;
    assign bus.out_last   = stream & (remaining == '0);
    assign bus.gen_enable = handshake;

`ifdef SEQ_SCHED_RESTART_EN
    assign bus.gen_restart = accept;
`else
    assign bus.gen_restart = 1'b0;
`endif

endmodule
